serial_word_receiver: RTL and testbench

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver_pkg.sv | 13 +
 rtl/fifo2_buf.sv | 69 ++++++
 rtl/serial_word_receiver.sv | 98 +++++++++
 tb/tb_serial_word_receiver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: FSM state encoding and
// the default payload width.
package serial_word_receiver_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/fifo2_buf.sv
// Two-entry word buffer with head/tail registers; head is always the oldest word.
// A push into a full buffer is ignored unless a pop happens on the same edge.
module fifo2_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic              vld_o,
  output logic              full_o,
  output logic [DATA_W-1:0] dat_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_pop;
  logic              do_push;

  assign vld_o  = (cnt_q != 2'd0);
  assign full_o = (cnt_q == 2'd2);
  assign dat_o  = head_q;

  assign do_pop  = pop_i && vld_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_dat_i;
        else               tail_d = push_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the incoming word lands behind
        // whatever survives the pop.
        if (cnt_q == 2'd1) begin
          head_d = push_dat_i;
        end else begin
          head_d = tail_q;
          tail_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Deserialises frames (start 1, DATA_W bits MSB first, stop 0) into a 2-entry
// buffer with valid/ready output, frame-error pulse and sticky overrun flag.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Y_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID_OUT,
  input  logic              READY_IN,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  input  logic              CLR_OVR
);

  localparam int CNT_W = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              push;
  logic              pop;
  logic              buf_full;

  assign pop = VALID_OUT && READY_IN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Y_IN) begin
          state_d = DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end
      end
      DATA: begin
        shift_d = {shift_q[DATA_W-2:0], Y_IN};
        if (cnt_q == '0) state_d = STOP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      STOP: begin
        // Always return to IDLE so a bad stop bit of 1 is never a new start.
        state_d = IDLE;
        if (Y_IN) ferr_d = 1'b1;
        else      push   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (push && buf_full && !pop) ovr_d = 1'b1;
    else if (CLR_OVR)             ovr_d = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  fifo2_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i      (CLOCK),
    .rst_i      (RESET),
    .push_i     (push),
    .push_dat_i (shift_q),
    .pop_i      (pop),
    .vld_o      (VALID_OUT),
    .full_o     (buf_full),
    .dat_o      (DATA_OUT)
  );

  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver with hand-computed expectations.
module tb_serial_word_receiver;

  localparam int DW = 8;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          Y_IN = 1'b0;
  logic          READY_IN = 1'b0;
  logic          CLR_OVR = 1'b0;
  logic [DW-1:0] DATA_OUT;
  logic          VALID_OUT;
  logic          FRAME_ERR;
  logic          OVERRUN;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK = ~CLOCK;

  serial_word_receiver #(.DATA_W(DW)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .Y_IN      (Y_IN),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT),
    .READY_IN  (READY_IN),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .CLR_OVR   (CLR_OVR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    Y_IN = b;
    tick();
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    send_bit(1'b1);
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    send_data(d);
    send_bit(stop);
  endtask

  task automatic pop();
    READY_IN = 1'b1;
    tick();
    READY_IN = 1'b0;
  endtask

  initial begin
    // Reset with every other input active: reset must win.
    RESET = 1'b1; Y_IN = 1'b1; READY_IN = 1'b1; CLR_OVR = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(VALID_OUT), 32'd0);
    chk("rst_data",  32'(DATA_OUT),  32'd0);
    chk("rst_ferr",  32'(FRAME_ERR), 32'd0);
    chk("rst_ovr",   32'(OVERRUN),   32'd0);
    RESET = 1'b0; Y_IN = 1'b0; READY_IN = 1'b0; CLR_OVR = 1'b0;

    // Quiet line: nothing may happen.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_outputs", 32'({VALID_OUT, FRAME_ERR, OVERRUN, DATA_OUT}), 32'd0);
    end

    // Good frame 0xA5, consumer stalled.
    send_data(8'hA5);
    chk("a5_pre_stop_valid", 32'(VALID_OUT), 32'd0);
    send_bit(1'b0);
    chk("a5_valid", 32'(VALID_OUT), 32'd1);
    chk("a5_data",  32'(DATA_OUT),  32'hA5);
    chk("a5_ferr",  32'(FRAME_ERR), 32'd0);
    tick();
    chk("a5_stable", 32'(DATA_OUT), 32'hA5);
    pop();
    chk("a5_popped", 32'(VALID_OUT), 32'd0);

    // Bad stop bit, then recovery.
    send_frame(8'h3C, 1'b1);
    chk("3c_ferr",  32'(FRAME_ERR), 32'd1);
    chk("3c_valid", 32'(VALID_OUT), 32'd0);
    send_bit(1'b0);
    chk("3c_ferr_one_cycle", 32'(FRAME_ERR), 32'd0);
    chk("3c_no_ovr",         32'(OVERRUN),   32'd0);
    send_frame(8'h11, 1'b0);
    chk("11_valid", 32'(VALID_OUT), 32'd1);
    chk("11_data",  32'(DATA_OUT),  32'h11);
    pop();

    // Back-to-back frames into a stalled buffer: third word overruns.
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b0);
    chk("b2b_no_ovr_yet", 32'(OVERRUN),  32'd0);
    chk("b2b_head_01",    32'(DATA_OUT), 32'h01);
    send_frame(8'h03, 1'b0);
    chk("b2b_ovr",     32'(OVERRUN),   32'd1);
    chk("b2b_valid",   32'(VALID_OUT), 32'd1);
    chk("b2b_head_ok", 32'(DATA_OUT),  32'h01);
    // Clear held through another overrun: the new overrun must win.
    CLR_OVR = 1'b1;
    send_frame(8'h04, 1'b0);
    chk("ovr_set_wins", 32'(OVERRUN), 32'd1);
    tick();
    chk("ovr_cleared", 32'(OVERRUN), 32'd0);
    CLR_OVR = 1'b0;
    pop();
    chk("b2b_second_data",  32'(DATA_OUT),  32'h02);
    chk("b2b_second_valid", 32'(VALID_OUT), 32'd1);
    pop();
    chk("b2b_drained", 32'(VALID_OUT), 32'd0);

    // Full buffer with a pop on the third stop edge.
    send_frame(8'h01, 1'b0);
    send_frame(8'h02, 1'b0);
    send_data(8'h03);
    READY_IN = 1'b1;
    send_bit(1'b0);
    READY_IN = 1'b0;
    chk("full_pp_head",  32'(DATA_OUT),  32'h02);
    chk("full_pp_valid", 32'(VALID_OUT), 32'd1);
    chk("full_pp_ovr",   32'(OVERRUN),   32'd0);
    pop();
    chk("full_pp_next_data",  32'(DATA_OUT),  32'h03);
    chk("full_pp_next_valid", 32'(VALID_OUT), 32'd1);
    pop();
    chk("full_pp_drained", 32'(VALID_OUT), 32'd0);

    // One entry with push and pop on the same edge.
    send_frame(8'h07, 1'b0);
    send_data(8'h08);
    READY_IN = 1'b1;
    send_bit(1'b0);
    READY_IN = 1'b0;
    chk("one_pp_head",  32'(DATA_OUT),  32'h08);
    chk("one_pp_valid", 32'(VALID_OUT), 32'd1);
    pop();
    chk("one_pp_drained", 32'(VALID_OUT), 32'd0);

    // Reset in the middle of frame 0xFF after four data bits.
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    Y_IN  = 1'b0;
    for (int i = 0; i < DW + 4; i++) begin
      tick();
      chk("midrst_quiet", 32'({VALID_OUT, FRAME_ERR}), 32'd0);
    end
    send_frame(8'h5A, 1'b0);
    chk("5a_valid", 32'(VALID_OUT), 32'd1);
    chk("5a_data",  32'(DATA_OUT),  32'h5A);
    Y_IN = 1'b0;
    pop();
    chk("5a_drained", 32'(VALID_OUT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
